// File: rtl/dmem_access_unit_if.sv
// rtl/dmem_access_unit_if.sv - pipeline request/response and dmem bus bundle for dmem_access_unit
interface dmem_access_unit_if;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_address;
  logic [31:0] mem_data_out;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_data_in;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_data_in,
    input  busy, resp_valid, resp_rdata, resp_fault,
    input  mem_address, mem_data_out, mem_write, mem_read
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_data_in,
    output busy, resp_valid, resp_rdata, resp_fault,
    output mem_address, mem_data_out, mem_write, mem_read
  );
endinterface

// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - MA-stage RV32I load/store controller for a word-only dmem
// Optional: define DMEM_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses.
module dmem_access_unit #(
  parameter int MEM_DEPTH = 1024
) (
  input  logic clk,
  input  logic reset,
  dmem_access_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD, WSETUP, WPULSE, RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  addr_lo_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdata_q;
  logic        write_q;
  logic [31:0] resp_rdata_q;
  logic        resp_fault_q;
  logic [31:0] mem_address_q;
  logic [31:0] mem_data_out_q;
  logic        mem_write_q;

  logic [29:0] req_idx;
  logic        range_fault;
  logic        funct3_fault;
  logic        misalign_fault;
  logic        acc_fault;

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] a,
                                                input logic [2:0] f);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f[1:0])
      2'b00:   return f[2] ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   return f[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [1:0] a,
                                               input logic [2:0] f, input logic [31:0] d);
    logic [31:0] m;
    m = w;
    if (f[1:0] == 2'b00) begin
      m[{a, 3'b000} +: 8] = d[7:0];
    end else if (a[1]) begin
      m[31:16] = d[15:0];
    end else begin
      m[15:0] = d[15:0];
    end
    return m;
  endfunction

  always_comb begin
    req_idx      = bus.req_addr[31:2];
    range_fault  = ({2'b00, req_idx} >= 32'(MEM_DEPTH));
    if (bus.req_write) begin
      funct3_fault = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      funct3_fault = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign_fault = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    misalign_fault = 1'b0;
`endif
    acc_fault = range_fault || funct3_fault || misalign_fault;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (acc_fault)                      state_d = RESP;
          else if (!bus.req_write)            state_d = RD;
          else if (bus.req_funct3 == 3'b010)  state_d = WSETUP;
          else                                state_d = RD;
        end
      end
      RD:      state_d = write_q ? WSETUP : RESP;
      WSETUP:  state_d = WPULSE;
      WPULSE:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      addr_lo_q      <= '0;
      funct3_q       <= '0;
      wdata_q        <= '0;
      write_q        <= 1'b0;
      resp_rdata_q   <= '0;
      resp_fault_q   <= 1'b0;
      mem_address_q  <= '0;
      mem_data_out_q <= '0;
      mem_write_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      // Registered strobe: high exactly while state is WPULSE.
      mem_write_q <= (state_d == WPULSE);
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            addr_lo_q    <= bus.req_addr[1:0];
            funct3_q     <= bus.req_funct3;
            wdata_q      <= bus.req_wdata;
            write_q      <= bus.req_write;
            resp_fault_q <= acc_fault;
            if (acc_fault) begin
              resp_rdata_q <= '0;
            end else begin
              mem_address_q <= {2'b00, req_idx};
              if (bus.req_write) mem_data_out_q <= bus.req_wdata;
            end
          end
        end
        RD: begin
          if (write_q) mem_data_out_q <= store_merge(bus.mem_data_in, addr_lo_q, funct3_q, wdata_q);
          else         resp_rdata_q   <= load_extract(bus.mem_data_in, addr_lo_q, funct3_q);
        end
        WPULSE:  resp_rdata_q <= '0;
        default: ;
      endcase
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.resp_valid   = (state_q == RESP);
  assign bus.resp_rdata   = resp_rdata_q;
  assign bus.resp_fault   = resp_fault_q;
  assign bus.mem_address  = mem_address_q;
  assign bus.mem_data_out = mem_data_out_q;
  assign bus.mem_write    = mem_write_q;
  assign bus.mem_read     = (state_q == RD);

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb/tb_dmem_access_unit.sv - directed and randomized bench for dmem_access_unit with a byte-level reference memory
module tb_dmem_access_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;

  dmem_access_unit_if bus();

  dmem_access_unit #(.MEM_DEPTH(1024)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] dmem    [1024];
  logic [31:0] ref_mem [1024];
  int          vectors = 0;
  int          miscompares = 0;
  int          wr_edges = 0;
  int          rd_cycles = 0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  assign bus.mem_data_in = bus.mem_read ? dmem[bus.mem_address[9:0]] : 32'hBAD0_BAD0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge bus.mem_write) begin
    wr_edges++;
    last_wr_addr = bus.mem_address;
    last_wr_data = bus.mem_data_out;
    dmem[bus.mem_address[9:0]] = bus.mem_data_out;
  end

  always @(negedge bus.mem_write) begin
    if (!reset) begin
      check("wr_addr_stable", bus.mem_address, last_wr_addr);
      check("wr_data_stable", bus.mem_data_out, last_wr_data);
    end
  end

  always @(posedge clk) if (bus.mem_read === 1'b1) rd_cycles++;

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},       32'(bus.busy), 32'h0);
    check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'h0);
    check({tag, "_resp_rdata"}, bus.resp_rdata, 32'h0);
    check({tag, "_resp_fault"}, 32'(bus.resp_fault), 32'h0);
    check({tag, "_mem_write"},  32'(bus.mem_write), 32'h0);
    check({tag, "_mem_read"},   32'(bus.mem_read), 32'h0);
    check({tag, "_mem_addr"},   bus.mem_address, 32'h0);
    check({tag, "_mem_dout"},   bus.mem_data_out, 32'h0);
  endtask

  // Reference: computes the architectural outcome of one access from RV32I rules.
  task automatic access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rdata, output logic fault);
    logic [29:0] idx;
    logic        legal, mis, e_fault;
    int          nbytes, off, e_lat, e_reads, e_writes, lat, rd0, wr0;
    logic [31:0] mask, val, word, e_rdata;
    idx    = a[31:2];
    nbytes = 1 << f3[1:0];
    if (nbytes > 4) nbytes = 4;
    off    = (int'(a[1:0]) / nbytes) * nbytes;
    legal  = w ? (f3 inside {3'b000, 3'b001, 3'b010})
               : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    mis    = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis    = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
`endif
    e_fault  = (idx >= 30'd1024) || !legal || mis;
    e_rdata  = '0;
    e_writes = 0;
    e_reads  = 0;
    if (e_fault) begin
      e_lat = 1;
    end else if (!w) begin
      e_lat   = 2;
      e_reads = 1;
      mask    = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
      val     = (ref_mem[idx[9:0]] >> (8 * off)) & mask;
      if (!f3[2] && nbytes < 4 && val[8 * nbytes - 1]) val = val | ~mask;
      e_rdata = val;
    end else begin
      e_lat    = (nbytes == 4) ? 3 : 4;
      e_reads  = (nbytes == 4) ? 0 : 1;
      e_writes = 1;
      word     = ref_mem[idx[9:0]];
      for (int i = 0; i < nbytes; i++) word[8 * (off + i) +: 8] = d[8 * i +: 8];
      ref_mem[idx[9:0]] = word;
    end

    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    rd0 = rd_cycles;
    wr0 = wr_edges;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency",    32'(lat), 32'(e_lat));
    check("busy_resp",  32'(bus.busy), 32'h1);
    check("resp_fault", 32'(bus.resp_fault), 32'(e_fault));
    check("resp_rdata", bus.resp_rdata, e_rdata);
    check("mem_reads",  32'(rd_cycles - rd0), 32'(e_reads));
    check("mem_writes", 32'(wr_edges - wr0), 32'(e_writes));
    if (e_writes != 0) check("wr_index", last_wr_addr, {2'b00, idx});
    rdata = bus.resp_rdata;
    fault = bus.resp_fault;
    @(posedge clk); #1;
    check("idle_busy",  32'(bus.busy), 32'h0);
    check("rdata_held", bus.resp_rdata, e_rdata);
  endtask

  logic [31:0] rd;
  logic        flt;
  logic [2:0]  legal_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    for (int i = 0; i < 1024; i++) begin
      dmem[i]    = '0;
      ref_mem[i] = '0;
    end
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, flt);
    access(1'b0, 3'b010, 32'h10, 32'h0, rd, flt);
    check("tp_lw", rd, 32'hDEADBEEF);
    access(1'b1, 3'b000, 32'h12, 32'h0000_0055, rd, flt);
    access(1'b0, 3'b010, 32'h10, 32'h0, rd, flt);
    check("tp_sb_lw", rd, 32'hDE55BEEF);
    access(1'b0, 3'b000, 32'h13, 32'h0, rd, flt);
    check("tp_lb", rd, 32'hFFFFFFDE);
    access(1'b0, 3'b100, 32'h13, 32'h0, rd, flt);
    check("tp_lbu", rd, 32'h000000DE);
    access(1'b1, 3'b001, 32'h10, 32'h0000_1234, rd, flt);
    access(1'b0, 3'b010, 32'h10, 32'h0, rd, flt);
    check("tp_sh_lw", rd, 32'hDE551234);
    access(1'b0, 3'b001, 32'h12, 32'h0, rd, flt);
    check("tp_lh", rd, 32'hFFFFDE55);
    access(1'b0, 3'b101, 32'h12, 32'h0, rd, flt);
    check("tp_lhu", rd, 32'h0000DE55);
    access(1'b0, 3'b010, 32'h1000, 32'h0, rd, flt);
    check("tp_range_fault", 32'(flt), 32'h1);

    // Reset while an SW to word 5 sits in WSETUP.
    begin
      int wr0;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b1;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 32'h14;
      bus.req_wdata  = 32'hCAFEF00D;
      wr0 = wr_edges;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check("abort_busy_before", 32'(bus.busy), 32'h1);
      reset = 1'b1;
      #1;
      check_outputs_zero("abort");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("abort_no_write", 32'(wr_edges - wr0), 32'h0);
    end
    access(1'b0, 3'b010, 32'h14, 32'h0, rd, flt);
    check("tp_abort_lw", rd, 32'h0);

    access(1'b0, 3'b010, 32'h11, 32'h0, rd, flt);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("tp_misalign_fault", 32'(flt), 32'h1);
`else
    check("tp_misalign_mask", rd, 32'hDE551234);
`endif

    for (int n = 0; n < 150; n++) begin
      logic        w;
      logic [2:0]  f3;
      logic [31:0] a;
      w  = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 99) < 85) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom);
      case ($urandom_range(0, 9))
        0:       a = 32'h1000 + 32'($urandom_range(0, 255));
        1:       a = $urandom;
        default: a = 32'($urandom_range(0, 63));
      endcase
      access(w, f3, a, $urandom, rd, flt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Initiator-side controller in the MA stage that drives the word-only data memory (dmem) on behalf of pipeline loads and stores.
- Converts RV32I byte, halfword and word accesses (funct3 encoding) into word-indexed dmem transactions.
- Sub-word stores use a read-modify-write sequence.
- Produces sign- or zero-extended load results.
- Generates a clean mem_write rising edge, because dmem writes on posedge mem_write.
- Stalls the pipeline via busy until each access completes.

Parameters:
- MEM_DEPTH, 1024, number of 32-bit words in dmem. Word index width is clog2(MEM_DEPTH).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  pipeline access request
- req_write  input  1  1 = store, 0 = load
- req_funct3  input  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- req_addr  input  32  byte address
- req_wdata  input  32  store data (low bits used for SB/SH)
- busy  output  1  high whenever state != IDLE; pipeline must hold its request
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load data; 0 for stores
- resp_fault  output  1  access faulted (range, misaligned or illegal funct3)
- mem_address  output  32  word index, {0, req_addr[31:2]}
- mem_data_out  output  32  write data to dmem
- mem_write  output  1  dmem write strobe (dmem writes on its rising edge)
- mem_read  output  1  dmem read enable
- mem_data_in  input  32  dmem read data (combinational, valid while mem_read = 1)

Behaviour:
- Reset (async, active-high):
  - state = IDLE.
  - All outputs 0, including mem_write, mem_read, resp_valid and resp_rdata.
- Request capture:
  - A request is accepted on a clk edge when state == IDLE and req_valid = 1.
  - addr, funct3, wdata and write are registered at acceptance; later changes on req_* are ignored until the next IDLE.
- FSM states:
  - IDLE, RD, WSETUP, WPULSE, RESP.
- Transitions from IDLE on acceptance:
  - Fault (word index >= MEM_DEPTH, or illegal funct3: 011/110/111 for loads, anything other than 000/001/010 for stores) -> RESP with resp_fault = 1 and no dmem activity.
  - Load -> RD.
  - SW -> WSETUP.
  - SB/SH -> RD (read phase of read-modify-write).
- RD:
  - mem_read = 1 and mem_address driven.
  - At the clk edge, mem_data_in is latched into an internal word register.
  - Load -> RESP. SB/SH -> WSETUP.
- WSETUP:
  - mem_address and mem_data_out driven stable; mem_write = 0.
  - mem_data_out for SW: wdata.
  - mem_data_out for SB: latched word with byte lane addr[1:0] replaced by wdata[7:0].
  - mem_data_out for SH: latched word with halfword lane addr[1] replaced by wdata[15:0].
  - Next state: WPULSE.
- WPULSE:
  - mem_write = 1 for exactly one cycle; address and data held unchanged.
  - Next state: RESP.
  - mem_write must come from a register (glitch-free).
- RESP:
  - resp_valid = 1 for exactly one cycle; busy is still 1.
  - Next state: IDLE.
  - mem_address and mem_data_out hold their values through RESP, so they stay stable at the mem_write falling edge.
- Load extraction (little-endian):
  - Byte lane = addr[1:0], halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Latency, acceptance edge to resp_valid high:
  - Load: 2 cycles.
  - SW: 3 cycles.
  - SB/SH: 4 cycles.
  - Fault: 1 cycle.
- Back-to-back: the next request can be accepted on the first edge after RESP (in IDLE).
- Outside RD, mem_read = 0.
- resp_rdata is held until the next RESP; resp_fault is cleared at the next acceptance.
- Reset mid-operation: aborts immediately.
  - mem_write and mem_read drop to 0 asynchronously.
  - A pending write that has not reached WPULSE is not performed.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - Halfword access with addr[0] = 1, or word access with addr[1:0] != 0, faults.
  - Path is IDLE -> RESP with resp_fault = 1; no dmem activity.
- Undefined:
  - Low address bits are silently masked to natural alignment: addr[0] is ignored for halfword, addr[1:0] for word.
  - The access proceeds normally and resp_fault reflects only range and funct3 faults.

Test Plan:
- Reset, then SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10:
  - mem_address = 4, one mem_write pulse in WPULSE.
  - LW returns resp_rdata = 0xDEADBEEF, resp_valid 2 cycles after acceptance.
- With word 4 = 0xDEADBEEF, SB addr 0x12 wdata 0x55 then LW 0x10:
  - SB performs one RD and one write; LW returns 0xDE55BEEF.
  - Loads from 0x13: LB = 0xFFFFFFDE, LBU = 0x000000DE.
- With word 4 = 0xDE55BEEF, SH addr 0x10 wdata 0x1234 then LH/LHU 0x12:
  - Word becomes 0xDE551234.
  - LH returns 0xFFFFDE55; LHU returns 0x0000DE55.
- LW addr 0x1000 (word 1024 >= MEM_DEPTH):
  - resp_fault = 1 one cycle after acceptance; mem_read and mem_write never asserted.
- Assert reset during WSETUP of an SW to word 5 holding 0x0:
  - All outputs 0 immediately, no mem_write edge.
  - A subsequent LW 0x14 returns 0x0.
- LW addr 0x11:
  - With DMEM_MISALIGN_TRAP_EN: fault, no dmem access.
  - Without: returns the word at 0x10.
